// File: rtl/mdu_sequencer_pkg.sv
// mdu_sequencer_pkg: shared encodings for the multiply/divide sequencer.
//   - MDU_* op selects driven from the decoder.
//   - MDU_S_* 3-bit sequencer state encodings.
//   - ALU_* control codes understood by the private ALU.
//   - Small decode helpers for the op select.
package mdu_sequencer_pkg;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  typedef enum logic [2:0] {
    MDU_S_IDLE   = 3'd0,
    MDU_S_PREP_A = 3'd1,
    MDU_S_PREP_B = 3'd2,
    MDU_S_ITER   = 3'd3,
    MDU_S_FIX_LO = 3'd4,
    MDU_S_FIX_HI = 3'd5,
    MDU_S_DONE   = 3'd6
  } mdu_state_e;

  localparam logic [3:0] ALU_ADDU     = 4'h0;
  localparam logic [3:0] ALU_SUBU     = 4'h1;
  localparam logic [3:0] ALU_AND      = 4'h2;
  localparam logic [3:0] ALU_OR       = 4'h3;
  localparam logic [3:0] ALU_XOR      = 4'h4;
  localparam logic [3:0] ALU_NOR      = 4'h5;
  localparam logic [3:0] ALU_SLT      = 4'h6;
  localparam logic [3:0] ALU_SLTU     = 4'h7;
  localparam logic [3:0] ALU_BYPASS_A = 4'h8;

  // Signed ops get magnitude preparation and a sign fix-up at the end.
  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_sequencer_alu.sv
// mdu_sequencer_alu: purely combinational 32-bit ALU reused by the sequencer.
// Ports:
//   a, b  : operands
//   ctrl  : ALU_* control code
//   y     : result
module mdu_sequencer_alu
  import mdu_sequencer_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  ctrl,
  output logic [31:0] y
);

  always_comb begin
    y = a;
    case (ctrl)
      ALU_ADDU:     y = a + b;
      ALU_SUBU:     y = a - b;
      ALU_AND:      y = a & b;
      ALU_OR:       y = a | b;
      ALU_XOR:      y = a ^ b;
      ALU_NOR:      y = ~(a | b);
      ALU_SLT:      y = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU:     y = {31'd0, a < b};
      ALU_BYPASS_A: y = a;
      default:      y = a;
    endcase
  end

endmodule

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: multi-cycle MULT/MULTU/DIV/DIVU engine for the EX stage.
// Operands are reduced to magnitudes, then 32 shift-add (multiply) or
// shift-subtract (divide) iterations run through one private ALU, followed
// by a two-cycle sign fix-up. Latency is fixed: done pulses 37 cycles after
// start is sampled. Owns the architectural HI/LO registers.
//
// Configuration macro: MDU_DIV_EN. When undefined, the divide datapath is
// removed; DIV/DIVU still walk every state with the ALU idle and finish with
// HI/LO unchanged.
//
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   start, mdu_op   : launch request and op select (sampled only in IDLE)
//   rs_val, rt_val  : multiplicand/dividend, multiplier/divisor
//   hi_we, lo_we    : MTHI/MTLO strobes, wdata their data (IDLE only)
//   busy            : op in flight (cycles 1..36 after start)
//   done            : one-cycle pulse with hi/lo valid
//   hi, lo          : architectural HI/LO
module mdu_sequencer
  import mdu_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  mdu_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  mdu_state_e  state_q;
  logic [1:0]  op_q;
  logic        sa_q, sb_q;      // operand signs captured at launch
  logic [31:0] opa_q, opb_q;    // raw operands, then magnitudes after PREP
  logic [31:0] acc_hi_q, acc_lo_q;
  logic [4:0]  cnt_q;
  logic        busy_q, done_q;
  logic [31:0] hi_q, lo_q;

  logic [31:0] alu_a, alu_b, alu_y;
  logic [3:0]  alu_ctrl;

  logic signed_op, is_div, run_dp, neg_res;
  logic fix_lo_neg, fix_hi_neg, mul_carry;
  logic [31:0] acc_hi_fix;

`ifdef MDU_DIV_EN
  logic        rem_neg;
  logic [31:0] div_sh;
  logic        div_ge;
`endif

  mdu_sequencer_alu u_alu (
    .a    (alu_a),
    .b    (alu_b),
    .ctrl (alu_ctrl),
    .y    (alu_y)
  );

  always_comb begin
    signed_op = op_is_signed(op_q);
    is_div    = op_is_div(op_q);
    neg_res   = signed_op & (sa_q ^ sb_q);
`ifdef MDU_DIV_EN
    run_dp  = 1'b1;
    rem_neg = signed_op & sa_q;
    div_sh  = {acc_hi_q[30:0], acc_lo_q[31]};
    // A set top bit means the shifted partial remainder exceeds 32 bits,
    // so it is certainly >= the divisor.
    div_ge  = acc_hi_q[31] | (div_sh >= opb_q);
`else
    run_dp  = ~is_div;
`endif
    fix_lo_neg = run_dp & neg_res;
    if (!is_div) begin
      fix_hi_neg = neg_res;
    end else begin
`ifdef MDU_DIV_EN
      fix_hi_neg = rem_neg;
`else
      fix_hi_neg = 1'b0;
`endif
    end
    // Wraparound in the add means a carry out of bit 31.
    mul_carry  = acc_lo_q[0] & (alu_y < acc_hi_q);
    acc_hi_fix = fix_hi_neg ? alu_y : acc_hi_q;
  end

  // ALU operand/control muxes.
  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_ctrl = ALU_BYPASS_A;
    unique case (state_q)
      MDU_S_PREP_A: begin
        if (run_dp && signed_op && sa_q) begin
          alu_b    = opa_q;
          alu_ctrl = ALU_SUBU;
        end else begin
          alu_a = opa_q;
        end
      end
      MDU_S_PREP_B: begin
        if (run_dp && signed_op && sb_q) begin
          alu_b    = opb_q;
          alu_ctrl = ALU_SUBU;
        end else begin
          alu_a = opb_q;
        end
      end
      MDU_S_ITER: begin
        if (!is_div) begin
          alu_a    = acc_hi_q;
          alu_b    = opa_q;
          alu_ctrl = acc_lo_q[0] ? ALU_ADDU : ALU_BYPASS_A;
        end
`ifdef MDU_DIV_EN
        else begin
          alu_a    = div_sh;
          alu_b    = opb_q;
          alu_ctrl = ALU_SUBU;
        end
`endif
      end
      MDU_S_FIX_LO: begin
        if (fix_lo_neg) begin
          alu_b    = acc_lo_q;
          alu_ctrl = ALU_SUBU;
        end
      end
      MDU_S_FIX_HI: begin
        if (fix_hi_neg) begin
          // 64-bit negate: the high word only absorbs the +1 when the low
          // word is zero (negation preserves zero, so post-FIX_LO is fine).
          if (is_div || acc_lo_q == '0) begin
            alu_b    = acc_hi_q;
            alu_ctrl = ALU_SUBU;
          end else begin
            alu_a    = acc_hi_q;
            alu_ctrl = ALU_NOR;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= MDU_S_IDLE;
      op_q     <= MDU_MULT;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      unique case (state_q)
        MDU_S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            // A same-cycle MTHI/MTLO is dropped in favour of the launch.
            op_q    <= mdu_op;
            sa_q    <= rs_val[31];
            sb_q    <= rt_val[31];
            opa_q   <= rs_val;
            opb_q   <= rt_val;
            busy_q  <= 1'b1;
            state_q <= MDU_S_PREP_A;
          end else begin
            if (hi_we) hi_q <= wdata;
            if (lo_we) lo_q <= wdata;
          end
        end
        MDU_S_PREP_A: begin
          opa_q   <= alu_y;
          state_q <= MDU_S_PREP_B;
        end
        MDU_S_PREP_B: begin
          opb_q    <= alu_y;
          acc_hi_q <= '0;
          acc_lo_q <= is_div ? opa_q : alu_y;
          cnt_q    <= 5'd31;
          state_q  <= MDU_S_ITER;
        end
        MDU_S_ITER: begin
          if (!is_div) begin
            acc_hi_q <= {mul_carry, alu_y[31:1]};
            acc_lo_q <= {alu_y[0], acc_lo_q[31:1]};
          end
`ifdef MDU_DIV_EN
          else begin
            acc_hi_q <= div_ge ? alu_y : div_sh;
            acc_lo_q <= {acc_lo_q[30:0], div_ge};
          end
`endif
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == 5'd0) state_q <= MDU_S_FIX_LO;
        end
        MDU_S_FIX_LO: begin
          if (fix_lo_neg) acc_lo_q <= alu_y;
          state_q <= MDU_S_FIX_HI;
        end
        MDU_S_FIX_HI: begin
          acc_hi_q <= acc_hi_fix;
          if (run_dp) begin
            hi_q <= acc_hi_fix;
            lo_q <= acc_lo_q;
          end
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= MDU_S_DONE;
        end
        MDU_S_DONE: begin
          done_q  <= 1'b0;
          state_q <= MDU_S_IDLE;
        end
        default: state_q <= MDU_S_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
module tb_mdu_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  mdu_op;
  logic [31:0] rs_val, rt_val;
  logic        hi_we, lo_we;
  logic [31:0] wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  mdu_sequencer dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .mdu_op (mdu_op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .hi_we  (hi_we),
    .lo_we  (lo_we),
    .wdata  (wdata),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_bad = 0;
  logic [31:0] mdl_hi = '0;
  logic [31:0] mdl_lo = '0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference result {hi, lo} from plain arithmetic.
  function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic [31:0] ua, ub, q, r;
    logic sgn;
    sgn = (op == 2'b00) || (op == 2'b10);
    if (op == 2'b01) return {32'd0, a} * {32'd0, b};
    if (op == 2'b00) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      return sa * sb;
    end
    ua = (sgn && a[31]) ? -a : a;
    ub = (sgn && b[31]) ? -b : b;
    if (ub == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = ua;
    end else begin
      q = ua / ub;
      r = ua % ub;
    end
    if (sgn && (a[31] ^ b[31])) q = -q;
    if (sgn && a[31]) r = -r;
    return {r, q};
  endfunction

  // flags: 1 = stray start in cycle 10, 2 = MTHI while busy, 4 = MTLO with start
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input bit use_model, input int flags);
    exp_t e, got;
    int   done_cyc;
    logic [63:0] m;
    e.hi = ehi;
    e.lo = elo;
    if (use_model) begin
      m = ref_model(op, a, b);
      e.hi = m[63:32];
      e.lo = m[31:0];
    end
`ifndef MDU_DIV_EN
    if (op[1]) begin
      e.hi = mdl_hi;
      e.lo = mdl_lo;
    end
`endif
    sb_q.push_back(e);
    start  = 1'b1;
    mdu_op = op;
    rs_val = a;
    rt_val = b;
    if ((flags & 4) != 0) begin
      lo_we = 1'b1;
      wdata = 32'h1357_9BDF;
    end
    @(negedge clk);
    start  = 1'b0;
    lo_we  = 1'b0;
    rs_val = $urandom;
    rt_val = $urandom;
    done_cyc = 0;
    for (int cyc = 1; cyc <= 45 && done_cyc == 0; cyc++) begin
      if (done) done_cyc = cyc;
      else if (cyc <= 36) check_eq({name, " busy"}, 64'(busy), 64'd1);
      if (cyc == 1 && (flags & 4) != 0) check_eq({name, " dropped_mtlo"}, 64'(lo), 64'(mdl_lo));
      if (cyc == 10 && (flags & 1) != 0) begin
        start  = 1'b1;
        mdu_op = 2'b01;
        rs_val = 32'h0000_0003;
        rt_val = 32'h0000_0005;
      end
      if (cyc == 11) start = 1'b0;
      if (cyc == 15 && (flags & 2) != 0) begin
        hi_we = 1'b1;
        wdata = 32'hDEAD_BEEF;
      end
      if (cyc == 16 && (flags & 2) != 0) begin
        hi_we = 1'b0;
        check_eq({name, " busy_mthi"}, 64'(hi), 64'(mdl_hi));
      end
      @(negedge clk);
    end
    hi_we = 1'b0;
    start = 1'b0;
    check_eq({name, " done_cycle"}, 64'(done_cyc), 64'd37);
    got = sb_q.pop_front();
    if (done_cyc != 0) begin
      check_eq({name, " hi"}, 64'(hi), 64'(got.hi));
      check_eq({name, " lo"}, 64'(lo), 64'(got.lo));
    end
    mdl_hi = got.hi;
    mdl_lo = got.lo;
    // Now in cycle done_cyc + 1: idle, no second op launched.
    check_eq({name, " idle_busy"}, 64'(busy), 64'd0);
    check_eq({name, " idle_done"}, 64'(done), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    mdu_op = 2'b00;
    rs_val = '0;
    rt_val = '0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    wdata = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst busy", 64'(busy), 64'd0);
    check_eq("rst done", 64'(done), 64'd0);
    check_eq("rst hi", 64'(hi), 64'd0);
    check_eq("rst lo", 64'(lo), 64'd0);

    // MTLO / MTHI in IDLE.
    lo_we = 1'b1;
    wdata = 32'hAAAA_5555;
    @(negedge clk);
    lo_we = 1'b0;
    check_eq("mtlo", 64'(lo), 64'hAAAA_5555);
    hi_we = 1'b1;
    wdata = 32'h1111_2222;
    @(negedge clk);
    hi_we = 1'b0;
    check_eq("mthi", 64'(hi), 64'h1111_2222);
    mdl_hi = 32'h1111_2222;
    mdl_lo = 32'hAAAA_5555;

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0, 1);
    run_op("mult_m3x7", 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 2);
    run_op("mult_m1xm1", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1, 0, 4);
    run_op("mult_lo0", 2'b00, 32'h0001_0000, 32'hFFFF_0000, 32'hFFFF_FFFF, 32'd0, 0, 0);
    run_op("div_m7d2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 2);
    run_op("divu_100d7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 0, 4);
    run_op("divu_by0", 2'b11, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, 0, 0);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 0, 1);
    for (int i = 0; i < 6; i++) begin
      logic [1:0]  rop;
      logic [31:0] ra, rb;
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300));
      run_op("rand", rop, ra, rb, 32'd0, 32'd0, 1, 0);
    end

    // Reset in cycle 20 of a running op.
    start  = 1'b1;
    mdu_op = 2'b01;
    rs_val = 32'h0000_1234;
    rt_val = 32'h0000_5678;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midrst busy", 64'(busy), 64'd0);
    check_eq("midrst done", 64'(done), 64'd0);
    check_eq("midrst hi", 64'(hi), 64'd0);
    check_eq("midrst lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mdl_hi = '0;
    mdl_lo = '0;
    @(negedge clk);
    run_op("multu_6x7", 2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 0, 0);
    run_op("divu_after", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 0, 0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
